perf_counter_bank: RTL and testbench

- Bank of NUM_COUNTERS event counters; each counter's value is of the shared 64-bit `counter_t` type from `perf_pkg`.
- Counts single-cycle event pulses from the Cohort datapath (FIFO push/pop, TLB miss, stall, etc.).
- Provides a shadow snapshot and a valid/ready read port, consumed by the Cohort config/MMIO register block.
- Sits directly upstream of every consumer of `counter_t` values.

---
 rtl/perf_counter_bank_if.sv | 31 +++
 rtl/perf_counter_bank.sv | 124 ++++++++++++
 tb/tb_perf_counter_bank.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/perf_counter_bank_if.sv
// Shared counter type and the valid/ready read port of perf_counter_bank.
// master = requester (MMIO block), slave = counter bank.
package perf_pkg;
    typedef logic [63:0] counter_t;
endpackage

interface perf_counter_bank_if #(
    parameter int IDX_W = 3
);
    import perf_pkg::*;

    logic             rd_req_valid_i;
    logic             rd_req_ready_o;
    logic [IDX_W-1:0] rd_idx_i;
    logic             rd_shadow_i;
    logic             rd_resp_valid_o;
    logic             rd_resp_ready_i;
    counter_t         rd_data_o;
    logic             rd_ovf_o;
    logic             rd_err_o;

    modport master (
        output rd_req_valid_i, rd_idx_i, rd_shadow_i, rd_resp_ready_i,
        input  rd_req_ready_o, rd_resp_valid_o, rd_data_o, rd_ovf_o, rd_err_o
    );

    modport slave (
        input  rd_req_valid_i, rd_idx_i, rd_shadow_i, rd_resp_ready_i,
        output rd_req_ready_o, rd_resp_valid_o, rd_data_o, rd_ovf_o, rd_err_o
    );
endinterface

// File: rtl/perf_counter_bank.sv
// Bank of 64-bit event counters with shadow snapshot and a two-state read port.
// Optional COHORT_PERF_SATURATE_EN: counters saturate at all-ones instead of wrapping.
module perf_counter_lane
    import perf_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     inc,
    input  logic     clear,
    input  logic     snapshot,
    output counter_t cnt,
    output counter_t shadow,
    output logic     ovf
);
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            shadow <= '0;
            ovf    <= 1'b0;
        end else begin
            // Shadow takes the pre-update value and ignores clear.
            if (snapshot) shadow <= cnt;
            if (clear) begin
                cnt <= '0;
                ovf <= 1'b0;
            end else if (inc) begin
`ifdef COHORT_PERF_SATURATE_EN
                if (&cnt) ovf <= 1'b1;
                else      cnt <= cnt + 64'd1;
`else
                cnt <= cnt + 64'd1;
                if (&cnt) ovf <= 1'b1;
`endif
            end
        end
    end
endmodule

module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int NUM_COUNTERS = 8,
    parameter int IDX_W        = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic [NUM_COUNTERS-1:0] event_i,
    input  logic                    clear_i,
    input  logic                    snapshot_i,
    perf_counter_bank_if.slave      rd
);
    typedef enum logic { S_IDLE, S_RESP } state_t;

    logic [NUM_COUNTERS-1:0][63:0] live;
    logic [NUM_COUNTERS-1:0][63:0] shadow;
    logic [NUM_COUNTERS-1:0]       ovf;

    for (genvar k = 0; k < NUM_COUNTERS; k++) begin : g_lane
        perf_counter_lane u_lane (
            .clk      (clk_i),
            .rst      (rst_i),
            .inc      (enable_i & event_i[k]),
            .clear    (clear_i),
            .snapshot (snapshot_i),
            .cnt      (live[k]),
            .shadow   (shadow[k]),
            .ovf      (ovf[k])
        );
    end

    counter_t sel_live, sel_shadow;
    logic     sel_ovf, hit;

    // Loop-compare keeps out-of-range indices from reaching the arrays.
    always_comb begin
        sel_live   = '0;
        sel_shadow = '0;
        sel_ovf    = 1'b0;
        hit        = 1'b0;
        for (int k = 0; k < NUM_COUNTERS; k++) begin
            if (rd.rd_idx_i == IDX_W'(k)) begin
                sel_live   = live[k];
                sel_shadow = shadow[k];
                sel_ovf    = ovf[k];
                hit        = 1'b1;
            end
        end
    end

    state_t state;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state              <= S_IDLE;
            rd.rd_req_ready_o  <= 1'b1;
            rd.rd_resp_valid_o <= 1'b0;
            rd.rd_data_o       <= '0;
            rd.rd_ovf_o        <= 1'b0;
            rd.rd_err_o        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rd.rd_req_valid_i) begin
                        rd.rd_data_o       <= rd.rd_shadow_i ? sel_shadow : sel_live;
                        rd.rd_ovf_o        <= sel_ovf;
                        rd.rd_err_o        <= ~hit;
                        rd.rd_req_ready_o  <= 1'b0;
                        rd.rd_resp_valid_o <= 1'b1;
                        state              <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rd.rd_resp_ready_i) begin
                        rd.rd_req_ready_o  <= 1'b1;
                        rd.rd_resp_valid_o <= 1'b0;
                        state              <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: counting, clear/snapshot, wrap, backpressure, errors, reset.
module tb_perf_counter_bank;
    import perf_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, enable, clear, snapshot;
    logic [7:0] event_v;
    logic       rst6, enable6;
    logic [5:0] event6;
    logic       clear6, snapshot6;

    perf_counter_bank_if #(.IDX_W(3)) rd  ();
    perf_counter_bank_if #(.IDX_W(3)) rd6 ();

    perf_counter_bank #(.NUM_COUNTERS(8)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .event_i(event_v),
        .clear_i(clear), .snapshot_i(snapshot), .rd(rd)
    );

    perf_counter_bank #(.NUM_COUNTERS(6)) dut6 (
        .clk_i(clk), .rst_i(rst6), .enable_i(enable6), .event_i(event6),
        .clear_i(clear6), .snapshot_i(snapshot6), .rd(rd6)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input bit b6, input logic [2:0] idx, input logic shd,
                           output counter_t d, output logic o, output logic e,
                           output logic lat_ok, output logic rdy_in_resp);
        int w = 0;
        while (!(b6 ? rd6.rd_req_ready_o : rd.rd_req_ready_o) && w < 20) begin
            tick();
            w++;
        end
        if (b6) begin rd6.rd_req_valid_i = 1; rd6.rd_idx_i = idx; rd6.rd_shadow_i = shd; end
        else    begin rd.rd_req_valid_i  = 1; rd.rd_idx_i  = idx; rd.rd_shadow_i  = shd; end
        tick();
        rd.rd_req_valid_i = 0;
        rd6.rd_req_valid_i = 0;
        lat_ok      = b6 ? rd6.rd_resp_valid_o : rd.rd_resp_valid_o;
        rdy_in_resp = b6 ? rd6.rd_req_ready_o  : rd.rd_req_ready_o;
        d = b6 ? rd6.rd_data_o : rd.rd_data_o;
        o = b6 ? rd6.rd_ovf_o  : rd.rd_ovf_o;
        e = b6 ? rd6.rd_err_o  : rd.rd_err_o;
        if (b6) rd6.rd_resp_ready_i = 1; else rd.rd_resp_ready_i = 1;
        tick();
        rd.rd_resp_ready_i = 0;
        rd6.rd_resp_ready_i = 0;
    endtask

    task automatic test_reset();
        rst = 1; rst6 = 1;
        tick(); tick();
        rst = 0; rst6 = 0;
        n_vec++; if (rd.rd_req_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %b want 1", rd.rd_req_ready_o); end
        n_vec++; if (rd.rd_resp_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid got %b want 0", rd.rd_resp_valid_o); end
        n_vec++; if (rd.rd_data_o !== 64'd0) begin n_err++; $display("FAIL reset_data got %h want 0", rd.rd_data_o); end
        n_vec++; if (rd.rd_ovf_o !== 1'b0 || rd.rd_err_o !== 1'b0) begin n_err++; $display("FAIL reset_ovf_err got %b%b want 00", rd.rd_ovf_o, rd.rd_err_o); end
    endtask

    task automatic test_count();
        counter_t d; logic o, e, lat, rdy;
        enable = 1; event_v = 8'h01;
        repeat (10) tick();
        event_v = 8'h00;
        // Disabled events must not count.
        enable = 0; event_v = 8'h01;
        repeat (3) tick();
        event_v = 8'h00; enable = 1;
        do_read(0, 3'd0, 1'b0, d, o, e, lat, rdy);
        n_vec++; if (d !== 64'd10) begin n_err++; $display("FAIL count_data got %0d want 10", d); end
        n_vec++; if (o !== 1'b0 || e !== 1'b0) begin n_err++; $display("FAIL count_ovf_err got %b%b want 00", o, e); end
        n_vec++; if (lat !== 1'b1) begin n_err++; $display("FAIL count_latency resp_valid got %b want 1", lat); end
        n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL count_ready_in_resp got %b want 0", rdy); end
    endtask

    task automatic test_clear_snapshot();
        counter_t d; logic o, e, lat, rdy;
        event_v = 8'h04;
        repeat (5) tick();
        clear = 1; snapshot = 1; event_v = 8'h04;
        tick();
        clear = 0; snapshot = 0; event_v = 8'h00;
        do_read(0, 3'd2, 1'b1, d, o, e, lat, rdy);
        n_vec++; if (d !== 64'd5) begin n_err++; $display("FAIL snap_shadow2 got %0d want 5", d); end
        do_read(0, 3'd2, 1'b0, d, o, e, lat, rdy);
        n_vec++; if (d !== 64'd0) begin n_err++; $display("FAIL clear_live2 got %0d want 0", d); end
        do_read(0, 3'd0, 1'b1, d, o, e, lat, rdy);
        n_vec++; if (d !== 64'd10) begin n_err++; $display("FAIL snap_shadow0 got %0d want 10", d); end
        do_read(0, 3'd0, 1'b0, d, o, e, lat, rdy);
        n_vec++; if (d !== 64'd0) begin n_err++; $display("FAIL clear_live0 got %0d want 0", d); end
    endtask

    task automatic test_wrap();
        counter_t d; logic o, e, lat, rdy;
        counter_t exp1, exp2;
`ifdef COHORT_PERF_SATURATE_EN
        exp1 = 64'hFFFF_FFFF_FFFF_FFFF;
        exp2 = 64'hFFFF_FFFF_FFFF_FFFF;
`else
        exp1 = 64'd0;
        exp2 = 64'd1;
`endif
        force dut.g_lane[1].u_lane.cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        release dut.g_lane[1].u_lane.cnt;
        tick();
        event_v = 8'h02;
        tick();
        event_v = 8'h00;
        do_read(0, 3'd1, 1'b0, d, o, e, lat, rdy);
        n_vec++; if (d !== exp1) begin n_err++; $display("FAIL wrap_data got %h want %h", d, exp1); end
        n_vec++; if (o !== 1'b1) begin n_err++; $display("FAIL wrap_ovf got %b want 1", o); end
        event_v = 8'h02;
        tick();
        event_v = 8'h00;
        do_read(0, 3'd1, 1'b0, d, o, e, lat, rdy);
        n_vec++; if (d !== exp2 || o !== 1'b1) begin n_err++; $display("FAIL wrap_sticky got %h/%b want %h/1", d, o, exp2); end
        do_read(0, 3'd0, 1'b0, d, o, e, lat, rdy);
        n_vec++; if (o !== 1'b0) begin n_err++; $display("FAIL ovf_other_lane got %b want 0", o); end
    endtask

    task automatic test_backpressure();
        counter_t d; logic o, e, lat, rdy;
        rd.rd_req_valid_i = 1; rd.rd_idx_i = 3'd0; rd.rd_shadow_i = 0;
        tick();
        // Keep requesting a different index while the response is pending.
        rd.rd_idx_i = 3'd2;
        n_vec++; if (rd.rd_data_o !== 64'd0 || rd.rd_resp_valid_o !== 1'b1) begin n_err++; $display("FAIL bp_first got %h/%b want 0/1", rd.rd_data_o, rd.rd_resp_valid_o); end
        for (int i = 0; i < 5; i++) begin
            event_v = 8'h01;
            tick();
            n_vec++;
            if (rd.rd_data_o !== 64'd0 || rd.rd_req_ready_o !== 1'b0 || rd.rd_resp_valid_o !== 1'b1) begin
                n_err++; $display("FAIL bp_hold cycle %0d got data=%h rdy=%b vld=%b want 0/0/1", i, rd.rd_data_o, rd.rd_req_ready_o, rd.rd_resp_valid_o);
            end
        end
        event_v = 8'h00;
        rd.rd_req_valid_i = 0;
        rd.rd_resp_ready_i = 1;
        tick();
        rd.rd_resp_ready_i = 0;
        n_vec++; if (rd.rd_req_ready_o !== 1'b1 || rd.rd_resp_valid_o !== 1'b0) begin n_err++; $display("FAIL bp_release got rdy=%b vld=%b want 1/0", rd.rd_req_ready_o, rd.rd_resp_valid_o); end
        do_read(0, 3'd0, 1'b0, d, o, e, lat, rdy);
        n_vec++; if (d !== 64'd5) begin n_err++; $display("FAIL bp_after got %0d want 5", d); end
    endtask

    task automatic test_err();
        counter_t d; logic o, e, lat, rdy;
        enable6 = 1; event6 = 6'h3F;
        repeat (3) tick();
        event6 = 6'h00;
        do_read(1, 3'd7, 1'b0, d, o, e, lat, rdy);
        n_vec++; if (e !== 1'b1) begin n_err++; $display("FAIL err_flag got %b want 1", e); end
        n_vec++; if (d !== 64'd0 || o !== 1'b0) begin n_err++; $display("FAIL err_data got %h/%b want 0/0", d, o); end
        do_read(1, 3'd5, 1'b0, d, o, e, lat, rdy);
        n_vec++; if (d !== 64'd3 || e !== 1'b0) begin n_err++; $display("FAIL last_idx got %0d/%b want 3/0", d, e); end
        do_read(1, 3'd6, 1'b1, d, o, e, lat, rdy);
        n_vec++; if (e !== 1'b1 || d !== 64'd0) begin n_err++; $display("FAIL err_idx6 got %h/%b want 0/1", d, e); end
    endtask

    task automatic test_reset_mid();
        counter_t d; logic o, e, lat, rdy;
        event_v = 8'hFF; snapshot = 1;
        tick();
        snapshot = 0;
        tick();
        event_v = 8'h00;
        rd.rd_req_valid_i = 1; rd.rd_idx_i = 3'd3; rd.rd_shadow_i = 0;
        tick();
        rd.rd_req_valid_i = 0;
        n_vec++; if (rd.rd_resp_valid_o !== 1'b1) begin n_err++; $display("FAIL mid_in_resp got %b want 1", rd.rd_resp_valid_o); end
        rst = 1;
        tick();
        rst = 0;
        n_vec++; if (rd.rd_resp_valid_o !== 1'b0 || rd.rd_req_ready_o !== 1'b1) begin n_err++; $display("FAIL mid_reset got vld=%b rdy=%b want 0/1", rd.rd_resp_valid_o, rd.rd_req_ready_o); end
        do_read(0, 3'd3, 1'b0, d, o, e, lat, rdy);
        n_vec++; if (d !== 64'd0) begin n_err++; $display("FAIL mid_live3 got %0d want 0", d); end
        do_read(0, 3'd3, 1'b1, d, o, e, lat, rdy);
        n_vec++; if (d !== 64'd0) begin n_err++; $display("FAIL mid_shadow3 got %0d want 0", d); end
        do_read(0, 3'd1, 1'b0, d, o, e, lat, rdy);
        n_vec++; if (d !== 64'd0 || o !== 1'b0) begin n_err++; $display("FAIL mid_live1 got %h/%b want 0/0", d, o); end
    endtask

    initial begin
        rst = 1; enable = 0; clear = 0; snapshot = 0; event_v = '0;
        rst6 = 1; enable6 = 0; clear6 = 0; snapshot6 = 0; event6 = '0;
        rd.rd_req_valid_i = 0; rd.rd_idx_i = '0; rd.rd_shadow_i = 0; rd.rd_resp_ready_i = 0;
        rd6.rd_req_valid_i = 0; rd6.rd_idx_i = '0; rd6.rd_shadow_i = 0; rd6.rd_resp_ready_i = 0;
        test_reset();
        test_count();
        test_clear_snapshot();
        test_wrap();
        test_backpressure();
        test_err();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
